// File: rtl/counter_timer_low_if.sv
// Register bus for counter_timer_low: config, reload-value and count-value
// ports. The bus owner (CPU side) uses the master modport and the timer uses
// the slave modport.
`timescale 1ns/1ps

interface counter_timer_low_if;
   logic        reg_cfg_we;
   logic [31:0] reg_cfg_di;
   logic [31:0] reg_cfg_do;
   logic [3:0]  reg_val_we;
   logic [31:0] reg_val_di;
   logic [31:0] reg_val_do;
   logic [3:0]  reg_dat_we;
   logic [31:0] reg_dat_di;
   logic [31:0] reg_dat_do;

   modport master (
      output reg_cfg_we, reg_cfg_di, reg_val_we, reg_val_di, reg_dat_we, reg_dat_di,
      input  reg_cfg_do, reg_val_do, reg_dat_do
   );

   modport slave (
      input  reg_cfg_we, reg_cfg_di, reg_val_we, reg_val_di, reg_dat_we, reg_dat_di,
      output reg_cfg_do, reg_val_do, reg_dat_do
   );
endinterface

// File: rtl/counter_timer_low.sv
// counter_timer_low: low 32-bit word of a chainable up/down counter/timer.
// Counts continuously or one-shot, can chain into a high-word counter through
// strobe/is_offset/stop_in, and raises a one-cycle interrupt after each stop.
// Optional feature: define COUNTER_TIMER_LOW_CAPTURE_EN to add a cap_in
// rising-edge capture register on reg_cap_do; otherwise reg_cap_do is 0.
`timescale 1ns/1ps

module counter_timer_low (
   input  logic                      clkin,
   input  logic                      resetn,
   counter_timer_low_if.slave        bus,
   output logic                      strobe,
   output logic                      is_offset,
   output logic                      enable_out,
   input  logic                      enable_in,
   input  logic                      stop_in,
   output logic                      stop_out,
   output logic                      irq_out,
   input  logic                      cap_in,
   output logic [31:0]               reg_cap_do
);

   logic        r_enable;
   logic        r_oneshot;
   logic        r_updown;
   logic        r_chain;
   logic        r_irq_ena;
   logic [31:0] r_value_reset;
   logic [31:0] r_value_cur;
   logic        r_lastenable;
   logic        r_stop_out;
   logic        r_stop_prev;
   logic        r_strobe;
   logic        r_irq_out;

   logic        w_loc_enable;
   logic        w_at_top;
   logic        w_at_zero;
   logic [31:0] w_cur_inc;
   logic [31:0] w_cur_dec;
   logic        w_unused_cfg;

   // In chained mode the high word can hold the low word off via enable_in.
   assign w_loc_enable = r_chain ? (r_enable & enable_in) : r_enable;
   assign w_at_top     = (r_value_cur == r_value_reset);
   assign w_at_zero    = (r_value_cur == 32'd0);
   assign w_cur_inc    = r_value_cur + 32'd1;
   assign w_cur_dec    = r_value_cur - 32'd1;
   assign w_unused_cfg = ^bus.reg_cfg_di[31:5];

   assign bus.reg_cfg_do = {27'd0, r_irq_ena, r_chain, r_updown, r_oneshot, r_enable};
   assign bus.reg_val_do = r_value_reset;
   assign bus.reg_dat_do = r_value_cur;
   assign enable_out     = r_enable;
   assign strobe         = r_strobe;
   assign stop_out       = r_stop_out;
   assign irq_out        = r_irq_out;
   // Tells the high word that the next low-word step wraps, so it can look ahead.
   assign is_offset      = r_chain & r_updown & w_loc_enable & w_at_top;

   // Configuration bits and byte-writable reload value.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         r_enable      <= 1'b0;
         r_oneshot     <= 1'b0;
         r_updown      <= 1'b0;
         r_chain       <= 1'b0;
         r_irq_ena     <= 1'b0;
         r_value_reset <= 32'd0;
      end else begin
         if (bus.reg_cfg_we) begin
            r_enable  <= bus.reg_cfg_di[0];
            r_oneshot <= bus.reg_cfg_di[1];
            r_updown  <= bus.reg_cfg_di[2];
            r_chain   <= bus.reg_cfg_di[3];
            r_irq_ena <= bus.reg_cfg_di[4];
         end
         for (int b = 0; b < 4; b++) begin
            if (bus.reg_val_we[b]) r_value_reset[8*b +: 8] <= bus.reg_val_di[8*b +: 8];
         end
      end
   end

   // Count engine: software write wins, then start-up load, then up/down step.
   // NOTE: all state here uses <= so every branch reads the pre-edge values
   // of r_value_cur/r_stop_out regardless of statement order.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         r_value_cur  <= 32'd0;
         r_lastenable <= 1'b0;
         r_stop_out   <= 1'b0;
         r_strobe     <= 1'b0;
      end else begin
         r_lastenable <= w_loc_enable;
         r_strobe     <= 1'b0;
         if (|bus.reg_dat_we) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.reg_dat_we[b]) r_value_cur[8*b +: 8] <= bus.reg_dat_di[8*b +: 8];
            end
            if (!w_loc_enable) r_stop_out <= 1'b0;
         end else if (!w_loc_enable) begin
            r_stop_out <= 1'b0;
         end else if (!r_lastenable) begin
            r_value_cur <= r_updown ? 32'd0 : r_value_reset;
            r_stop_out  <= 1'b0;
         end else if (r_updown) begin
            if (w_at_top) begin
               // One-shot stops on its own when standalone, only with the high word when chained.
               if (r_oneshot && (!r_chain || stop_in)) begin
                  r_stop_out <= 1'b1;
               end else begin
                  r_value_cur <= 32'd0;
                  r_stop_out  <= 1'b0;
                  r_strobe    <= r_chain;
               end
            end else begin
               r_value_cur <= w_cur_inc;
               r_stop_out  <= ~r_chain & (w_cur_inc == 32'd0);
            end
         end else begin
            if (w_at_zero) begin
               if (r_oneshot && (!r_chain || stop_in)) begin
                  r_stop_out <= 1'b1;
               end else begin
                  r_value_cur <= r_value_reset;
                  r_stop_out  <= 1'b0;
                  r_strobe    <= r_chain;
               end
            end else begin
               r_value_cur <= w_cur_dec;
               r_stop_out  <= ~r_chain & (w_cur_dec == 32'd0);
            end
         end
      end
   end

   // Interrupt: one-cycle pulse the cycle after stop_out rises.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         r_stop_prev <= 1'b0;
         r_irq_out   <= 1'b0;
      end else begin
         r_stop_prev <= r_stop_out;
         r_irq_out   <= r_irq_ena & w_loc_enable & r_stop_out & ~r_stop_prev;
      end
   end

`ifdef COUNTER_TIMER_LOW_CAPTURE_EN
   logic        r_cap_prev;
   logic [31:0] r_cap_val;

   // Capture value_cur on a cap_in rising edge; a same-cycle count write is not yet visible.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         r_cap_prev <= 1'b0;
         r_cap_val  <= 32'd0;
      end else begin
         r_cap_prev <= cap_in;
         if (cap_in && !r_cap_prev) r_cap_val <= r_value_cur;
      end
   end

   assign reg_cap_do = r_cap_val;
`else
   logic w_unused_cap;
   assign w_unused_cap = cap_in;
   assign reg_cap_do   = 32'd0;
`endif

endmodule

// File: tb/tb_counter_timer_low.sv
// Directed self-checking bench for counter_timer_low: reset, standalone down
// count, write priority, freeze/restart, async reset, oneshot up count with
// IRQ, chained up count, chain stop and the optional capture register.
`timescale 1ns/1ps

module tb_counter_timer_low;

`ifdef COUNTER_TIMER_LOW_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic        clkin = 1'b0;
   logic        resetn;
   logic        strobe, is_offset, enable_out, stop_out, irq_out;
   logic        enable_in, stop_in, cap_in;
   logic [31:0] reg_cap_do;
   int          errors = 0;
   int          checks = 0;

   counter_timer_low_if bus ();

   counter_timer_low dut (
      .clkin      (clkin),
      .resetn     (resetn),
      .bus        (bus),
      .strobe     (strobe),
      .is_offset  (is_offset),
      .enable_out (enable_out),
      .enable_in  (enable_in),
      .stop_in    (stop_in),
      .stop_out   (stop_out),
      .irq_out    (irq_out),
      .cap_in     (cap_in),
      .reg_cap_do (reg_cap_do)
   );

   always #5 clkin = ~clkin;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic wr_cfg(input logic [31:0] d);
      bus.reg_cfg_we = 1'b1; bus.reg_cfg_di = d;
      tick();
      bus.reg_cfg_we = 1'b0;
   endtask

   task automatic wr_val(input logic [31:0] d);
      bus.reg_val_we = 4'hF; bus.reg_val_di = d;
      tick();
      bus.reg_val_we = 4'h0;
   endtask

   task automatic wr_dat(input logic [3:0] we, input logic [31:0] d);
      bus.reg_dat_we = we; bus.reg_dat_di = d;
      tick();
      bus.reg_dat_we = 4'h0;
   endtask

   initial begin
      logic [31:0] exp_cur[5];
      logic        exp_stop[5];
      logic        exp_stb[5];
      logic        exp_off[5];

      resetn = 1'b0;
      enable_in = 1'b0; stop_in = 1'b0; cap_in = 1'b0;
      bus.reg_cfg_we = 1'b0; bus.reg_cfg_di = 32'd0;
      bus.reg_val_we = 4'h0; bus.reg_val_di = 32'd0;
      bus.reg_dat_we = 4'h0; bus.reg_dat_di = 32'd0;

      // Reset state
      #12;
      chk("rst_cfg", bus.reg_cfg_do, 32'd0);
      chk("rst_val", bus.reg_val_do, 32'd0);
      chk("rst_dat", bus.reg_dat_do, 32'd0);
      chk("rst_outs", {27'd0, strobe, is_offset, enable_out, stop_out, irq_out}, 32'd0);
      chk("rst_cap", reg_cap_do, 32'd0);
      tick();
      resetn = 1'b1;

      // Standalone down count, reload 3, continuous: 3,2,1,0,3,2
      wr_val(32'd3);
      chk("down_val", bus.reg_val_do, 32'd3);
      wr_cfg(32'h01);
      chk("down_cfg", bus.reg_cfg_do, 32'h01);
      chk("down_en", {31'd0, enable_out}, 32'd1);
      chk("down_pre", bus.reg_dat_do, 32'd0);
      tick();
      chk("down_start", bus.reg_dat_do, 32'd3);
      chk("down_start_stop", {31'd0, stop_out}, 32'd0);
      exp_cur  = '{32'd2, 32'd1, 32'd0, 32'd3, 32'd2};
      exp_stop = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("down_cur%0d", i), bus.reg_dat_do, exp_cur[i]);
         chk($sformatf("down_stop%0d", i), {31'd0, stop_out}, {31'd0, exp_stop[i]});
         chk($sformatf("down_irq%0d", i), {31'd0, irq_out}, 32'd0);
      end

      // Byte write wins over the count in the same cycle
      wr_dat(4'b0001, 32'h0000_0055);
      chk("wr_prio", bus.reg_dat_do, 32'h55);
      tick();
      chk("wr_after", bus.reg_dat_do, 32'h54);

      // Disable mid-count freezes, re-enable restarts from reload
      wr_cfg(32'h00);
      chk("freeze_edge", bus.reg_dat_do, 32'h53);
      tick(); tick();
      chk("freeze_hold", bus.reg_dat_do, 32'h53);
      chk("freeze_stop", {31'd0, stop_out}, 32'd0);
      wr_cfg(32'h01);
      tick();
      chk("restart", bus.reg_dat_do, 32'd3);
      tick();
      chk("restart_cnt", bus.reg_dat_do, 32'd2);

      // Asynchronous reset mid-count
      resetn = 1'b0;
      #1;
      chk("arst_dat", bus.reg_dat_do, 32'd0);
      chk("arst_cfg", bus.reg_cfg_do, 32'd0);
      chk("arst_val", bus.reg_val_do, 32'd0);
      chk("arst_outs", {27'd0, strobe, is_offset, enable_out, stop_out, irq_out}, 32'd0);
      tick();
      resetn = 1'b1;

      // Oneshot up count with IRQ, reload 2, cfg 0x17
      wr_val(32'd2);
      wr_cfg(32'h17);
      tick();
      chk("os_start", bus.reg_dat_do, 32'd0);
      tick();
      chk("os_1", bus.reg_dat_do, 32'd1);
      tick();
      chk("os_2", bus.reg_dat_do, 32'd2);
      chk("os_2_stop", {31'd0, stop_out}, 32'd0);
      tick();
      chk("os_hold", bus.reg_dat_do, 32'd2);
      chk("os_stop", {31'd0, stop_out}, 32'd1);
      chk("os_irq_early", {31'd0, irq_out}, 32'd0);
      tick();
      chk("os_irq", {31'd0, irq_out}, 32'd1);
      tick();
      chk("os_irq_once", {31'd0, irq_out}, 32'd0);
      chk("os_hold2", bus.reg_dat_do, 32'd2);

      // Chained up count, reload 1, cfg 0x0D
      wr_cfg(32'h00);
      enable_in = 1'b1;
      stop_in   = 1'b0;
      wr_val(32'd1);
      wr_cfg(32'h0D);
      chk("ch_cfg", bus.reg_cfg_do, 32'h0D);
      exp_cur = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
      exp_stb = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_off = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("ch_cur%0d", i), bus.reg_dat_do, exp_cur[i]);
         chk($sformatf("ch_stb%0d", i), {31'd0, strobe}, {31'd0, exp_stb[i]});
         chk($sformatf("ch_off%0d", i), {31'd0, is_offset}, {31'd0, exp_off[i]});
      end

      // Chain stop: oneshot with stop_in holds at reload, no strobe
      stop_in = 1'b1;
      wr_cfg(32'h0F);
      chk("cs_step", bus.reg_dat_do, 32'd1);
      chk("cs_step_stb", {31'd0, strobe}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("cs_cur%0d", i), bus.reg_dat_do, 32'd1);
         chk($sformatf("cs_stop%0d", i), {31'd0, stop_out}, 32'd1);
         chk($sformatf("cs_stb%0d", i), {31'd0, strobe}, 32'd0);
         chk($sformatf("cs_off%0d", i), {31'd0, is_offset}, 32'd1);
      end

      // High word withdraws enable: everything quiet, value held
      enable_in = 1'b0;
      #1;
      chk("hi_off_comb", {31'd0, is_offset}, 32'd0);
      tick();
      chk("hi_off_stop", {31'd0, stop_out}, 32'd0);
      chk("hi_off_stb", {31'd0, strobe}, 32'd0);
      chk("hi_off_irq", {31'd0, irq_out}, 32'd0);
      chk("hi_off_cur", bus.reg_dat_do, 32'd1);

      // Capture (expects 0 when the capture feature is not built in)
      wr_cfg(32'h00);
      wr_dat(4'hF, 32'h10);
      chk("cap_preset", bus.reg_dat_do, 32'h10);
      cap_in = 1'b1;
      tick();
      chk("cap_rise", reg_cap_do, CAP ? 32'h10 : 32'h0);
      wr_dat(4'hF, 32'h20);
      tick(); tick(); tick();
      chk("cap_held", reg_cap_do, CAP ? 32'h10 : 32'h0);
      cap_in = 1'b0;
      tick();
      cap_in = 1'b1;
      wr_dat(4'hF, 32'h30);
      chk("cap_prewrite", reg_cap_do, CAP ? 32'h20 : 32'h0);
      chk("cap_wr", bus.reg_dat_do, 32'h30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/counter_timer_low.md
COUNTER_TIMER_LOW -- requirements
Module: counter_timer_low

Interface
REQ-001 Parameters: none; all widths fixed at 32 data bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clkin (input, 1, rising-edge clock) and resetn (input, 1, asynchronous active-low reset).
REQ-003 Register ports SHALL be:
- reg_cfg_we  input 1  config write strobe
- reg_cfg_di  input 32  config data
- reg_cfg_do  output 32  {27'd0, irq_ena, chain, updown, oneshot, enable}
REQ-004 Reload and count ports SHALL be:
- reg_val_we  input 4  reload byte enables
- reg_val_di  input 32  reload data
- reg_val_do  output 32  value_reset
- reg_dat_we  input 4  count byte enables
- reg_dat_di  input 32  count data
- reg_dat_do  output 32  value_cur
REQ-005 Chain ports to the high-word counter SHALL be:
- strobe  output 1  one-cycle wrap pulse, high word counts on it
- is_offset  output 1  high word compares its next value
- enable_out  output 1  = enable
- enable_in  input 1  enable from high word
- stop_in  input 1  high word reached its stop value
- stop_out  output 1  low-word stop flag
REQ-006 Remaining ports SHALL be:
- irq_out  output 1  interrupt pulse
- cap_in  input 1  capture event, synchronous to clkin
- reg_cap_do  output 32  captured count

Function
REQ-007 Config write (reg_cfg_we=1) SHALL load enable, oneshot, updown, chain and irq_ena from reg_cfg_di[0..4] on the next edge.
REQ-008 Each reg_val_we[n] SHALL write byte n of value_reset; each reg_dat_we[n] SHALL write byte n of value_cur.
REQ-009 A reg_dat_we write SHALL take priority over counting in the same cycle; counting, strobe and stop_out update are suppressed that cycle.
REQ-010 loc_enable SHALL be enable&enable_in when chain=1, else enable; lastenable SHALL register loc_enable every cycle.
REQ-011 On the first enabled cycle (loc_enable=1, lastenable=0), value_cur SHALL load 0 when updown=1, else value_reset, and stop_out SHALL clear.
REQ-012 Standalone up-count (chain=0, updown=1) SHALL work as follows:
- value_cur==value_reset with oneshot=0: value_cur<=0, stop_out<=0.
- value_cur==value_reset with oneshot=1: hold, stop_out<=1.
- otherwise: value_cur increments; stop_out<=1 iff value_cur+1 wraps to 0.
REQ-013 Standalone down-count SHALL work as follows:
- value_cur==0 with oneshot=0: reload value_reset.
- value_cur==0 with oneshot=1: hold, stop_out<=1.
- otherwise: decrement; stop_out<=1 iff the result is 0.
REQ-014 Chained up-count with value_cur==value_reset SHALL set value_cur<=0 and strobe<=1 for exactly one cycle, unless stop_in=1 and oneshot=1, in which case value_cur holds and stop_out<=1.
REQ-015 Chained down-count with value_cur==0 SHALL reload value_reset with strobe<=1, under the same stop_in/oneshot exception.
REQ-016 In chained mode with stop_in=1 and oneshot=0, the wrap of REQ-014/015 SHALL occur normally and stop_out<=0.
REQ-017 strobe SHALL be registered, 0 in all cases other than REQ-014/015, and 0 when chain=0.
REQ-018 is_offset SHALL be the combinational term chain&updown&loc_enable&(value_cur==value_reset).
REQ-019 With loc_enable=0, value_cur SHALL hold and stop_out, strobe and irq_out SHALL be 0.
REQ-020 irq_out SHALL pulse 1 for one cycle, one cycle after each stop_out rising edge, when irq_ena=1.
REQ-021 A config write clearing enable mid-count SHALL freeze value_cur on the next edge; re-enabling SHALL restart per REQ-011.

Reset
REQ-022 resetn=0 SHALL asynchronously clear enable, oneshot, updown, chain, irq_ena, value_reset, value_cur, lastenable, stop_out, strobe, irq_out and capture state; all outputs read 0.

Configuration
REQ-023 With COUNTER_TIMER_LOW_CAPTURE_EN defined, a cap_in rising edge (cap_in=1, registered previous value 0) SHALL latch value_cur into reg_cap_do on that edge.
REQ-024 The capture of REQ-023 SHALL be independent of loc_enable, and a simultaneous reg_dat_we SHALL capture the pre-write value.
REQ-025 Without COUNTER_TIMER_LOW_CAPTURE_EN, cap_in SHALL be ignored, reg_cap_do SHALL be constant 0 and no capture flops SHALL exist.

Verification
REQ-026 Standalone down count: value_reset=3, cfg=0x01 (down, continuous) -> value_cur sequence 3,2,1,0,3,...; stop_out=1 in the cycle value_cur=0.
REQ-027 Oneshot up count with IRQ: value_reset=2, cfg=0x17 -> value_cur 0,1,2 then holds; stop_out=1 after reaching 2; irq_out is a single one-cycle pulse one cycle later.
REQ-028 Chained up count: value_reset=1, cfg=0x0D, enable_in=1, stop_in=0 -> strobe pulses every 2nd cycle; is_offset=1 in the cycle value_cur==1.
REQ-029 Chain stop: same as REQ-028 with oneshot=1 and stop_in=1 asserted -> value_cur holds at 1, stop_out=1, no further strobe.
REQ-030 Write priority and reset: reg_dat_we=4'b0001 with di=0x55 during counting -> value_cur[7:0]=0x55, with no count that cycle; resetn pulsed low mid-count -> all outputs 0 immediately.
REQ-031 Capture (macro defined): counter at 0x10 when cap_in rises -> reg_cap_do=0x10; cap_in held high for 5 cycles -> no re-capture.
